// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and defaults for the DRAM port arbiter: request struct,
// default bus widths, port-index type and tag-width helper.
package dram_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_LINE_W = 128;
    localparam int MAX_PORTS  = 8;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LINE_W-1:0] wdata;
    } dram_req_t;

    // A two-port arbiter still needs a one-bit tag.
    function automatic int tag_width(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bus bundle between upstream requesters, the arbiter and the DRAM FIFO pair.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dram_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = dram_port_arbiter_pkg::DEF_ADDR_W,
    parameter int LINE_W    = dram_port_arbiter_pkg::DEF_LINE_W
);

    logic [NUM_PORTS-1:0]             up_req_valid;
    logic [NUM_PORTS-1:0]             up_req_ready;
    logic [NUM_PORTS-1:0]             up_req_we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] up_req_addr;
    logic [NUM_PORTS-1:0][LINE_W-1:0] up_req_wdata;
    logic [NUM_PORTS-1:0]             up_rsp_valid;
    logic [LINE_W-1:0]                up_rsp_rdata;

    logic                             dn_req_valid;
    logic                             dn_req_ready;
    logic                             dn_req_we;
    logic [ADDR_W-1:0]                dn_req_addr;
    logic [LINE_W-1:0]                dn_req_wdata;
    logic                             dn_rsp_valid;
    logic [LINE_W-1:0]                dn_rsp_rdata;

    modport slave (
        input  up_req_valid, up_req_we, up_req_addr, up_req_wdata,
        output up_req_ready, up_rsp_valid, up_rsp_rdata,
        output dn_req_valid, dn_req_we, dn_req_addr, dn_req_wdata,
        input  dn_req_ready, dn_rsp_valid, dn_rsp_rdata
    );

    modport master (
        output up_req_valid, up_req_we, up_req_addr, up_req_wdata,
        input  up_req_ready, up_rsp_valid, up_rsp_rdata,
        input  dn_req_valid, dn_req_we, dn_req_addr, dn_req_wdata,
        output dn_req_ready, dn_rsp_valid, dn_rsp_rdata
    );

endinterface

// File: rtl/dram_tag_fifo.sv
// In-order queue of requester tags for outstanding DRAM reads.
// Push is dropped when full and pop is ignored when empty.
module dram_tag_fifo #(
    parameter int  TAG_W = 1,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // always_ff sees the pre-edge values of its neighbours.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; count/pointers alone decide
    // which entries are valid, so the RAM can map to plain flops or LUTRAM.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin merge of N cache-line requesters onto one DRAM request stream,
// with an in-order tag queue routing read data back to the issuing port.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int LINE_W          = DEF_LINE_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    dram_port_arbiter_if.slave bus,
    output logic               err_orphan_rsp
);

    localparam int TAG_W = tag_width(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic             found;
        logic [TAG_W-1:0] idx;
    } pick_t;

    // Scan backwards so the eligible port closest to start is kept last.
    function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] elig,
                                      input logic [TAG_W-1:0]     start);
        pick_t            res;
        logic [TAG_W-1:0] idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = TAG_W'((int'(start) + k) % NUM_PORTS);
            if (elig[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    logic [TAG_W-1:0]     rr_ptr;
    logic                 out_valid;
    req_t                 out_req;
    logic [NUM_PORTS-1:0] rsp_onehot;
    logic [LINE_W-1:0]    rsp_data;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant_onehot;
    logic [NUM_PORTS-1:0] rsp_onehot_next;
    pick_t                pick;
    req_t                 grant_req;
    logic                 can_load;
    logic                 grant;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 orphan;

    logic                 tag_full;
    logic                 tag_empty;
    logic [TAG_W-1:0]     tag_head;
    logic [CNT_W-1:0]     tag_count;

    dram_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .push     (tag_push),
        .push_tag (pick.idx),
        .pop      (tag_pop),
        .head_tag (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise synthesis infers a latch.
        eligible        = '0;
        grant_onehot    = '0;
        rsp_onehot_next = '0;
        grant_req       = '0;

        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = bus.up_req_valid[i] && (bus.up_req_we[i] || !tag_full);
        end

        can_load = !out_valid || bus.dn_req_ready;
        pick     = rr_pick(eligible, rr_ptr);
        grant    = !rst && can_load && pick.found;
        if (grant) grant_onehot[pick.idx] = 1'b1;

        grant_req.we    = bus.up_req_we[pick.idx];
        grant_req.addr  = bus.up_req_addr[pick.idx];
        grant_req.wdata = bus.up_req_wdata[pick.idx];

        // Writes are posted; only reads need a return route.
        tag_push = grant && !grant_req.we;
        tag_pop  = bus.dn_rsp_valid && (tag_count != '0);
        orphan   = bus.dn_rsp_valid && tag_empty;
        if (tag_pop) rsp_onehot_next[tag_head] = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= '0;
            out_valid      <= 1'b0;
            out_req        <= '0;
            rsp_onehot     <= '0;
            rsp_data       <= '0;
            err_orphan_rsp <= 1'b0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_req   <= grant_req;
                rr_ptr    <= (pick.idx == TAG_W'(NUM_PORTS - 1)) ? '0 : pick.idx + 1'b1;
            end else if (bus.dn_req_ready) begin
                out_valid <= 1'b0;
            end

            rsp_onehot <= rsp_onehot_next;
            if (tag_pop) rsp_data <= bus.dn_rsp_rdata;
            if (orphan)  err_orphan_rsp <= 1'b1;
        end
    end

    assign bus.up_req_ready = grant_onehot;
    assign bus.up_rsp_valid = rsp_onehot;
    assign bus.up_rsp_rdata = rsp_data;
    assign bus.dn_req_valid = out_valid;
    assign bus.dn_req_we    = out_req.we;
    assign bus.dn_req_addr  = out_req.addr;
    assign bus.dn_req_wdata = out_req.wdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus random
// traffic compared against a transaction-level model with a tag queue.
module tb_dram_port_arbiter;

    localparam int NP   = 2;
    localparam int AW   = 27;
    localparam int LW   = 128;
    localparam int MAXO = 4;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic err_orphan_rsp;
    int   n_tests = 0;
    int   n_fail  = 0;

    dram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) bus();

    dram_port_arbiter #(
        .NUM_PORTS       (NP),
        .ADDR_W          (AW),
        .LINE_W          (LW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .bus            (bus.slave),
        .err_orphan_rsp (err_orphan_rsp)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state
    bit              m_valid;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_wdata;
    int              m_rr;
    int              tagq[$];
    logic [NP-1:0]   m_rsp;
    logic [LW-1:0]   m_rdata;
    bit              m_err;
    logic [NP-1:0]   got_ready;
    logic [NP-1:0]   exp_ready;
    int              exp_g;

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rr = 0;
        tagq.delete(); m_rsp = '0; m_rdata = '0; m_err = 0;
    endtask

    task automatic clear_inputs();
        bus.up_req_valid = '0; bus.up_req_we = '0;
        bus.up_req_addr = '0; bus.up_req_wdata = '0;
        bus.dn_req_ready = 1'b0; bus.dn_rsp_valid = 1'b0; bus.dn_rsp_rdata = '0;
    endtask

    task automatic set_port(input int p, input bit v, input bit we,
                            input logic [AW-1:0] a, input logic [LW-1:0] d);
        bus.up_req_valid[p] = v; bus.up_req_we[p] = we;
        bus.up_req_addr[p] = a;  bus.up_req_wdata[p] = d;
    endtask

    // Advance one clock: sample ready, predict the grant, then update the model.
    task automatic tick();
        int t;
        #1;
        got_ready = bus.up_req_ready;
        exp_g = -1;
        if (!m_valid || bus.dn_req_ready) begin
            for (int k = 0; k < NP; k++) begin
                int p = (m_rr + k) % NP;
                if (exp_g < 0 && bus.up_req_valid[p] && (bus.up_req_we[p] || tagq.size() < MAXO))
                    exp_g = p;
            end
        end
        exp_ready = '0;
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        @(posedge sys_clk);
        m_rsp = '0;
        if (bus.dn_rsp_valid) begin
            if (tagq.size() == 0) m_err = 1;
            else begin
                t = tagq.pop_front();
                m_rsp[t] = 1'b1;
                m_rdata = bus.dn_rsp_rdata;
            end
        end
        if (exp_g >= 0) begin
            m_valid = 1; m_we = bus.up_req_we[exp_g];
            m_addr = bus.up_req_addr[exp_g]; m_wdata = bus.up_req_wdata[exp_g];
            m_rr = (exp_g + 1) % NP;
            if (!m_we) tagq.push_back(exp_g);
        end else if (bus.dn_req_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        bus.up_req_valid = '1;
        bus.dn_req_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        n_tests++; if (bus.up_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_up_req_ready got=%b exp=00", bus.up_req_ready); end
        n_tests++; if (bus.dn_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_req_valid got=%b exp=0", bus.dn_req_valid); end
        n_tests++; if ({bus.dn_req_we, bus.dn_req_addr, bus.dn_req_wdata} !== '0) begin n_fail++; $display("FAIL reset_dn_req_fields got=%h exp=0", {bus.dn_req_we, bus.dn_req_addr, bus.dn_req_wdata}); end
        n_tests++; if (bus.up_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_up_rsp_valid got=%b exp=00", bus.up_rsp_valid); end
        n_tests++; if (bus.up_rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_up_rsp_rdata got=%h exp=0", bus.up_rsp_rdata); end
        n_tests++; if (err_orphan_rsp !== 1'b0) begin n_fail++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan_rsp); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic [LW-1:0] dead = {4{32'hDEADBEEF}};
        do_reset();
        bus.dn_req_ready = 1'b1;
        set_port(0, 1, 0, 27'h100, '0);
        tick();
        n_tests++; if (got_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", got_ready); end
        set_port(0, 0, 0, '0, '0);
        n_tests++; if (bus.dn_req_valid !== 1'b1) begin n_fail++; $display("FAIL single_dn_valid got=%b exp=1", bus.dn_req_valid); end
        n_tests++; if ({bus.dn_req_we, bus.dn_req_addr} !== {1'b0, 27'h100}) begin n_fail++; $display("FAIL single_dn_req got=%b/%h exp=0/100", bus.dn_req_we, bus.dn_req_addr); end
        tick();
        n_tests++; if (bus.dn_req_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", bus.dn_req_valid); end
        bus.dn_rsp_valid = 1'b1; bus.dn_rsp_rdata = dead;
        tick();
        bus.dn_rsp_valid = 1'b0; bus.dn_rsp_rdata = '0;
        n_tests++; if (bus.up_rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=01", bus.up_rsp_valid); end
        n_tests++; if (bus.up_rsp_rdata !== dead) begin n_fail++; $display("FAIL single_rsp_data got=%h exp=%h", bus.up_rsp_rdata, dead); end
        tick();
        n_tests++; if (bus.up_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_pulse got=%b exp=00", bus.up_rsp_valid); end
    endtask

    task automatic test_round_robin();
        int cnt0 = 0;
        int cnt1 = 0;
        logic [NP-1:0] exp;
        do_reset();
        bus.dn_req_ready = 1'b1;
        set_port(0, 1, 1, 27'h1000, {4{32'h0A0A0A0A}});
        set_port(1, 1, 1, 27'h2000, {4{32'h1B1B1B1B}});
        for (int c = 0; c < 16; c++) begin
            tick();
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++; if (got_ready !== exp) begin n_fail++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, got_ready, exp); end
            n_tests++; if (bus.dn_req_addr !== ((c % 2 == 0) ? 27'h1000 : 27'h2000)) begin n_fail++; $display("FAIL rr_dn_addr cycle=%0d got=%h", c, bus.dn_req_addr); end
            if (got_ready[0]) cnt0++;
            if (got_ready[1]) cnt1++;
        end
        n_tests++; if (cnt0 != 8 || cnt1 != 8) begin n_fail++; $display("FAIL rr_fairness got=%0d/%0d exp=8/8", cnt0, cnt1); end
        clear_inputs();
        bus.dn_req_ready = 1'b1;
        tick();
    endtask

    task automatic test_queue_full();
        do_reset();
        bus.dn_req_ready = 1'b1;
        for (int r = 0; r < MAXO; r++) begin
            set_port(1, 1, 0, 27'(32'h500 + r), '0);
            tick();
            n_tests++; if (got_ready !== 2'b10) begin n_fail++; $display("FAIL full_fill_%0d got=%b exp=10", r, got_ready); end
        end
        set_port(1, 1, 0, 27'h600, '0);
        set_port(0, 1, 1, 27'h40, {4{32'h5555AAAA}});
        tick();
        n_tests++; if (got_ready !== 2'b01) begin n_fail++; $display("FAIL full_write_passes got=%b exp=01", got_ready); end
        n_tests++; if ({bus.dn_req_we, bus.dn_req_addr} !== {1'b1, 27'h40}) begin n_fail++; $display("FAIL full_write_fwd got=%b/%h exp=1/40", bus.dn_req_we, bus.dn_req_addr); end
        set_port(0, 0, 0, '0, '0);
        tick();
        n_tests++; if (got_ready !== 2'b00) begin n_fail++; $display("FAIL full_read_blocked got=%b exp=00", got_ready); end
        bus.dn_rsp_valid = 1'b1; bus.dn_rsp_rdata = {4{32'h11112222}};
        tick();
        n_tests++; if (got_ready !== 2'b00) begin n_fail++; $display("FAIL full_pop_no_bypass got=%b exp=00", got_ready); end
        bus.dn_rsp_valid = 1'b0;
        n_tests++; if (bus.up_rsp_valid !== 2'b10) begin n_fail++; $display("FAIL full_pop_rsp got=%b exp=10", bus.up_rsp_valid); end
        tick();
        n_tests++; if (got_ready !== 2'b10) begin n_fail++; $display("FAIL full_read_resumes got=%b exp=10", got_ready); end
        n_tests++; if (bus.dn_req_addr !== 27'h600) begin n_fail++; $display("FAIL full_read_addr got=%h exp=600", bus.dn_req_addr); end
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] wd = {4{32'hCAFEF00D}};
        do_reset();
        bus.dn_req_ready = 1'b1;
        set_port(0, 1, 0, 27'h200, wd);
        tick();
        set_port(0, 0, 0, '0, '0);
        set_port(1, 1, 1, 27'h300, {4{32'h77778888}});
        bus.dn_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++; if (got_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready cycle=%0d got=%b exp=00", c, got_ready); end
            n_tests++; if ({bus.dn_req_valid, bus.dn_req_we, bus.dn_req_addr, bus.dn_req_wdata} !== {1'b1, 1'b0, 27'h200, wd}) begin n_fail++; $display("FAIL bp_hold cycle=%0d got=%b/%h", c, bus.dn_req_valid, bus.dn_req_addr); end
        end
        bus.dn_req_ready = 1'b1;
        tick();
        n_tests++; if (got_ready !== 2'b10) begin n_fail++; $display("FAIL bp_resume got=%b exp=10", got_ready); end
        n_tests++; if (bus.dn_req_addr !== 27'h300) begin n_fail++; $display("FAIL bp_resume_addr got=%h exp=300", bus.dn_req_addr); end
    endtask

    task automatic test_interleaved();
        logic [LW-1:0] d [3];
        logic [NP-1:0] exp_v [3];
        d[0] = {4{32'hAAAA0001}}; d[1] = {4{32'hBBBB0002}}; d[2] = {4{32'hCCCC0003}};
        exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
        do_reset();
        bus.dn_req_ready = 1'b1;
        set_port(0, 1, 0, 27'h10, '0); tick(); set_port(0, 0, 0, '0, '0);
        set_port(1, 1, 0, 27'h20, '0); tick(); set_port(1, 0, 0, '0, '0);
        set_port(0, 1, 0, 27'h30, '0); tick();
        n_tests++; if (got_ready !== 2'b01) begin n_fail++; $display("FAIL inter_third_grant got=%b exp=01", got_ready); end
        set_port(0, 0, 0, '0, '0);
        for (int r = 0; r < 3; r++) begin
            bus.dn_rsp_valid = 1'b1; bus.dn_rsp_rdata = d[r];
            tick();
            n_tests++; if (bus.up_rsp_valid !== exp_v[r]) begin n_fail++; $display("FAIL inter_rsp_port_%0d got=%b exp=%b", r, bus.up_rsp_valid, exp_v[r]); end
            n_tests++; if (bus.up_rsp_rdata !== d[r]) begin n_fail++; $display("FAIL inter_rsp_data_%0d got=%h exp=%h", r, bus.up_rsp_rdata, d[r]); end
        end
        bus.dn_rsp_valid = 1'b0;
        tick();
        n_tests++; if (err_orphan_rsp !== 1'b0) begin n_fail++; $display("FAIL inter_no_orphan got=%b exp=0", err_orphan_rsp); end
    endtask

    task automatic test_orphan_and_reset();
        do_reset();
        bus.dn_rsp_valid = 1'b1; bus.dn_rsp_rdata = {4{32'h0BADF00D}};
        tick();
        bus.dn_rsp_valid = 1'b0;
        n_tests++; if (err_orphan_rsp !== 1'b1) begin n_fail++; $display("FAIL orphan_set got=%b exp=1", err_orphan_rsp); end
        n_tests++; if (bus.up_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL orphan_dropped got=%b exp=00", bus.up_rsp_valid); end
        repeat (3) tick();
        n_tests++; if (err_orphan_rsp !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan_rsp); end
        // Mid-traffic reset: read in flight, request held by backpressure.
        bus.dn_req_ready = 1'b1;
        set_port(1, 1, 0, 27'h700, '0);
        tick();
        bus.dn_req_ready = 1'b0;
        set_port(0, 1, 1, 27'h710, '0);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (bus.dn_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dn_valid got=%b exp=0", bus.dn_req_valid); end
        n_tests++; if (bus.up_req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_ready got=%b exp=00", bus.up_req_ready); end
        n_tests++; if (err_orphan_rsp !== 1'b0) begin n_fail++; $display("FAIL midrst_err got=%b exp=0", err_orphan_rsp); end
        n_tests++; if (bus.dn_req_addr !== '0) begin n_fail++; $display("FAIL midrst_addr got=%h exp=0", bus.dn_req_addr); end
        model_reset();
        @(posedge sys_clk);
        #1 rst = 1'b0;
        bus.dn_req_ready = 1'b1;
        set_port(0, 1, 1, 27'h720, '0);
        set_port(1, 1, 1, 27'h730, '0);
        tick();
        n_tests++; if (got_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_rr_zero got=%b exp=01", got_ready); end
        clear_inputs();
        bus.dn_rsp_valid = 1'b1;
        tick();
        bus.dn_rsp_valid = 1'b0;
        n_tests++; if (err_orphan_rsp !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight_orphan got=%b exp=1", err_orphan_rsp); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                         AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
            end
            bus.dn_req_ready = ($urandom_range(0, 3) != 0);
            bus.dn_rsp_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.dn_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_tests++; if (got_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, got_ready, exp_ready); end
            n_tests++; if (bus.dn_req_valid !== m_valid) begin n_fail++; $display("FAIL rand_dn_valid cycle=%0d got=%b exp=%b", c, bus.dn_req_valid, m_valid); end
            if (m_valid) begin
                n_tests++; if ({bus.dn_req_we, bus.dn_req_addr, bus.dn_req_wdata} !== {m_we, m_addr, m_wdata}) begin n_fail++; $display("FAIL rand_dn_req cycle=%0d got=%b/%h exp=%b/%h", c, bus.dn_req_we, bus.dn_req_addr, m_we, m_addr); end
            end
            n_tests++; if (bus.up_rsp_valid !== m_rsp) begin n_fail++; $display("FAIL rand_rsp_valid cycle=%0d got=%b exp=%b", c, bus.up_rsp_valid, m_rsp); end
            if (m_rsp != '0) begin
                n_tests++; if (bus.up_rsp_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rsp_data cycle=%0d got=%h exp=%h", c, bus.up_rsp_rdata, m_rdata); end
            end
            n_tests++; if (err_orphan_rsp !== m_err) begin n_fail++; $display("FAIL rand_err cycle=%0d got=%b exp=%b", c, err_orphan_rsp, m_err); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_queue_full();
        test_backpressure();
        test_interleaved();
        test_orphan_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Parametrised N-port arbiter that merges cache-line requests from several requesters (I-cache, D-cache, future DMA) onto the single master-side request stream feeding the DRAM request FIFO. Grants round-robin, registers the granted request, and records the port of every read in an in-order tag queue so DRAM read data is routed back to the requester that issued it. It replaces the single-requester hookup between the cache and the DRAM FIFO pair.

## Interface
- NUM_PORTS, 2, number of upstream requesters (2..8)
- ADDR_W, 27, line address width
- LINE_W, 128, cache-line data width
- MAX_OUTSTANDING, 4, read tag queue depth (power of two, >=2)
- sys_clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- up_req_valid  in  NUM_PORTS  per-port request valid
- up_req_ready  out  NUM_PORTS  per-port accept (one-hot or zero)
- up_req_we  in  NUM_PORTS  1 = line write, 0 = line read
- up_req_addr  in  NUM_PORTS x ADDR_W  per-port line address
- up_req_wdata  in  NUM_PORTS x LINE_W  per-port write line
- up_rsp_valid  out  NUM_PORTS  one-hot read-data strobe
- up_rsp_rdata  out  LINE_W  read line, shared by all ports
- dn_req_valid  out  1  request to DRAM FIFO valid
- dn_req_ready  in  1  DRAM FIFO can accept
- dn_req_we / dn_req_addr / dn_req_wdata  out  1 / ADDR_W / LINE_W  forwarded request
- dn_rsp_valid  in  1  read line returned by DRAM side (no backpressure)
- dn_rsp_rdata  in  LINE_W  returned line
- err_orphan_rsp  out  1  sticky: response arrived with empty tag queue

## Operation
- Eligible port i: up_req_valid[i] and (up_req_we[i] or tag queue not full).
- Round-robin: search starts at rr_ptr; first eligible port wins. After a grant to port g, rr_ptr <= (g+1) mod NUM_PORTS.
- Grant fires when output register empty or being drained (dn_req_valid && dn_req_ready) this cycle. up_req_ready[g]=1 only for the winner on such cycles; all others 0.
- On grant: output register loads {we, addr, wdata} of port g; reads also push g into tag queue.
- Writes are posted: no tag, no response.
- dn_rsp_valid: pop head tag t; next cycle up_rsp_valid = one-hot(t), up_rsp_rdata = dn_rsp_rdata. DRAM side returns reads in issue order; ordering across ports is issue order.
- dn_rsp_valid with empty queue: drop, set err_orphan_rsp (cleared only by rst).
- Tag queue full: reads on all ports blocked, writes still granted. Push and pop in the same cycle are allowed whenever not full; full blocks the push even if a pop coincides (no rsp->ready combinational path).
- Reset mid-operation: queue, output register, rr_ptr cleared; in-flight DRAM responses after reset raise err_orphan_rsp.

## Timing
- Reset values: up_req_ready 0, dn_req_valid 0, dn_req_we/addr/wdata 0, up_rsp_valid 0, up_rsp_rdata 0, err_orphan_rsp 0, rr_ptr 0, tag count 0.
- Accept at edge N -> dn_req_valid high from N+1; holds stable until dn_req_ready sampled high.
- Back-to-back: sustained one request per cycle while dn_req_ready stays high.
- Response latency: dn_rsp_valid at edge M -> up_rsp_valid pulse for exactly cycle M+1.
- up_req_ready depends combinationally on up_req_valid, dn_req_ready, queue count; no other comb paths.
- Tag count width clog2(MAX_OUTSTANDING)+1; pointers wrap modulo MAX_OUTSTANDING.

## Structure
- Shared memory package: dram_req_t {we, addr, wdata} struct, ADDR_W/LINE_W defaults, port-index typedef.
- One sub-module: dram_tag_fifo (synchronous FIFO of clog2(NUM_PORTS)-bit tags, depth MAX_OUTSTANDING, full/empty/count).
- Round-robin pick as a function inside the arbiter.

## Test plan
- Single port read addr 0x100, dn_req_ready=1 -> dn_req_valid cycle after accept, addr 0x100 we=0; dn_rsp 0xDEAD.. -> up_rsp_valid=2'b01 next cycle with same data.
- Both ports valid continuously, ready=1 -> grants alternate 0,1,0,1; no port starved over 16 cycles.
- Port 1 issues 4 reads, no responses -> 5th read blocked (ready 0), port 0 write to 0x40 still forwarded; one response pops, read accepted next cycle.
- dn_req_ready held low 5 cycles -> dn_req_addr/we/wdata stable, no further up_req_ready, resumes on release.
- Interleaved reads P0@0x10, P1@0x20, P0@0x30 -> responses A,B,C delivered to ports 0,1,0 in order.
- dn_rsp_valid with empty queue -> err_orphan_rsp 1 and stays; rst asserted mid-traffic -> all outputs reset values immediately, rr_ptr 0.
